// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bus bundle between one core's fetch stage, its slice of the
//                shared instruction memory and its control unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              start;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_opcode;
    logic [DATA_W-1:0] instr_operand;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    // Fetch-stage side
    modport master (
        input  start, im_data, instr_ready, redirect_valid, redirect_pc,
        output im_addr, instr_valid, instr_opcode, instr_operand, instr_pc, halted
    );

    // Memory / control-unit side
    modport slave (
        output start, im_data, instr_ready, redirect_valid, redirect_pc,
        input  im_addr, instr_valid, instr_opcode, instr_operand, instr_pc, halted
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Per-core instruction fetch stage. Reads one- and two-word
//                instructions from a one-cycle-latency memory and presents
//                them as opcode/operand pairs over a valid/ready handshake.
//                Handles jump redirects and ENDOP halt.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter logic [DATA_W-1:0]  OP_LDAC  = DATA_W'(5),
    parameter logic [DATA_W-1:0]  OP_STAC  = DATA_W'(7),
    parameter logic [DATA_W-1:0]  OP_JPNZ  = DATA_W'(28),
    parameter logic [DATA_W-1:0]  OP_JPPZ  = DATA_W'(30),
    parameter logic [DATA_W-1:0]  OP_ENDOP = DATA_W'(42)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    instr_fetch_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_OP  = 3'd1,
        S_CAP_OP  = 3'd2,
        S_REQ_ARG = 3'd3,
        S_CAP_ARG = 3'd4,
        S_PRESENT = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [DATA_W-1:0] opc_q, opc_d;
    logic [DATA_W-1:0] opr_q, opr_d;

    // Opcodes followed by an operand word
    function automatic logic is_two_word(input logic [DATA_W-1:0] op);
        return (op == OP_LDAC) || (op == OP_STAC) ||
               (op == OP_JPNZ) || (op == OP_JPPZ);
    endfunction

    // State and datapath registers; reset aborts any fetch in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ipc_q   <= '0;
            opc_q   <= '0;
            opr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ipc_q   <= ipc_d;
            opc_q   <= opc_d;
            opr_q   <= opr_d;
        end
    end

    // Next-state and datapath logic; redirect outranks everything but IDLE
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ipc_d   = ipc_q;
        opc_d   = opc_q;
        opr_d   = opr_q;

        if ((state_q != S_IDLE) && bus.redirect_valid) begin
            // In-flight memory word is dropped simply by restarting at REQ_OP
            pc_d    = bus.redirect_pc;
            addr_d  = bus.redirect_pc;
            state_d = S_REQ_OP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_d    = '0;
                        addr_d  = '0;
                        state_d = S_REQ_OP;
                    end
                end
                S_REQ_OP: state_d = S_CAP_OP;
                S_CAP_OP: begin
                    // im_data is only looked at in the capture states
                    opc_d = bus.im_data;
                    ipc_d = pc_q;
                    if (is_two_word(bus.im_data)) begin
                        addr_d  = pc_q + ADDR_W'(1);
                        state_d = S_REQ_ARG;
                    end else begin
                        opr_d   = '0;
                        state_d = S_PRESENT;
                    end
                end
                S_REQ_ARG: state_d = S_CAP_ARG;
                S_CAP_ARG: begin
                    opr_d   = bus.im_data;
                    state_d = S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.instr_ready) begin
                        if (opc_q == OP_ENDOP) begin
                            // Address bus stays parked on the ENDOP word
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + (is_two_word(opc_q) ? ADDR_W'(2) : ADDR_W'(1));
                            addr_d  = pc_d;
                            state_d = S_REQ_OP;
                        end
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.im_addr       = addr_q;
    assign bus.instr_valid   = (state_q == S_PRESENT);
    assign bus.instr_opcode  = opc_q;
    assign bus.instr_operand = opr_q;
    assign bus.instr_pc      = ipc_q;
    assign bus.halted        = (state_q == S_HALT);

endmodule
`default_nettype wire
